// File: rtl/tipi_rpi_shift_master.sv
// tipi_rpi_shift_master
//   Clocked serial master for the RPi side of the TIPI CPLD shift interface.
//   Each accepted command moves one byte: a read pulls TD/TC out of the CPLD
//   (load pulse, then 8 shift clocks), a write pushes RD/RC into it (8 shift
//   clocks, then a latch pulse). Every phase lasts CLK_DIV system clocks and
//   every r_* line comes straight from a flop.
//
// Ports
//   clk, reset            system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle)
//   cmd_write, cmd_ctrl   direction (1 = write) and register select (1 = ctrl)
//   cmd_data[0:7]         write byte, bit 0 goes out first
//   rsp_valid, rsp_data   one-cycle completion strobe, read byte or write echo
//   busy                  inverse of cmd_ready
//   r_clk, r_dc, r_rt,
//   r_le, r_dout, r_din   CPLD shift interface
module tipi_rpi_shift_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_ctrl,
    input  logic [0:7] cmd_data,
    output logic       rsp_valid,
    output logic [0:7] rsp_data,
    output logic       busy,
    output logic       r_clk,
    output logic       r_dc,
    output logic       r_rt,
    output logic       r_le,
    output logic       r_dout,
    input  logic       r_din
);

    typedef enum logic [3:0] {
        S_IDLE, S_SETUP, S_LOAD_HI, S_LOAD_LO, S_SHIFT_LO,
        S_SHIFT_HI, S_LATCH, S_HOLD, S_DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic [2:0] r_bit, w_bit_nxt;
    logic       r_wr;
    logic [0:7] r_data;
    logic [0:7] r_rx;
    logic       w_phase_end;
    logic       w_accept;
    logic       w_clk_nxt, w_le_nxt, w_dout_nxt;

    assign w_phase_end = (r_cnt == DIV_LAST);
    assign w_accept    = cmd_valid && (r_state == S_IDLE);
    assign busy        = ~cmd_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_state_nxt = S_SETUP;
                w_bit_nxt   = 3'd0;
            end
            S_SETUP:    if (w_phase_end) w_state_nxt = r_wr ? S_SHIFT_LO : S_LOAD_HI;
            S_LOAD_HI:  if (w_phase_end) w_state_nxt = S_LOAD_LO;
            S_LOAD_LO:  if (w_phase_end) w_state_nxt = S_SHIFT_LO;
            S_SHIFT_LO: if (w_phase_end) w_state_nxt = S_SHIFT_HI;
            S_SHIFT_HI: if (w_phase_end) begin
                if (r_bit == 3'd7) begin
                    w_state_nxt = r_wr ? S_LATCH : S_DONE;
                end else begin
                    w_state_nxt = S_SHIFT_LO;
                    w_bit_nxt   = r_bit + 3'd1;
                end
            end
            S_LATCH:    if (w_phase_end) w_state_nxt = S_HOLD;
            S_HOLD:     if (w_phase_end) w_state_nxt = S_DONE;
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase

        // Divider restarts on every phase change and idles at 0.
        if (w_state_nxt != r_state || r_state == S_IDLE) w_cnt_nxt = 8'd0;
        else                                           w_cnt_nxt = r_cnt + 8'd1;

        // Line values are decoded from the next state so the flops below
        // present them for exactly the cycles spent in that state.
        w_clk_nxt  = (w_state_nxt == S_LOAD_HI) || (w_state_nxt == S_SHIFT_HI);
        w_le_nxt   = (w_state_nxt == S_LOAD_HI) || (w_state_nxt == S_LOAD_LO) ||
                     (w_state_nxt == S_LATCH);
        // Bit stays on r_dout through the latch phase; HOLD and idle drive 0.
        w_dout_nxt = 1'b0;
        if (r_wr && ((w_state_nxt == S_SHIFT_LO) || (w_state_nxt == S_SHIFT_HI) ||
                     (w_state_nxt == S_LATCH)))
            w_dout_nxt = r_data[w_bit_nxt];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= 8'd0;
            r_bit     <= 3'd0;
            r_wr      <= 1'b0;
            r_data    <= 8'h00;
            r_rx      <= 8'h00;
            r_clk     <= 1'b0;
            r_le      <= 1'b0;
            r_dout    <= 1'b0;
            r_rt      <= 1'b0;
            r_dc      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            cmd_ready <= 1'b1;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_clk     <= w_clk_nxt;
            r_le      <= w_le_nxt;
            r_dout    <= w_dout_nxt;
            cmd_ready <= (w_state_nxt == S_IDLE);
            rsp_valid <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                r_wr   <= cmd_write;
                r_data <= cmd_data;
                r_rt   <= ~cmd_write;
                r_dc   <= cmd_ctrl;
            end
            // CPLD updates r_din on rising r_clk, so take it at the end of
            // the low phase, just before our own rising edge.
            if (r_state == S_SHIFT_LO && w_phase_end && !r_wr)
                r_rx[r_bit] <= r_din;
            if (w_state_nxt == S_DONE)
                rsp_data <= r_wr ? r_data : r_rx;
        end
    end

endmodule
